// File: rtl/srl_bus.sv
// Multi-lane addressable shift register: WIDTH-bit words shift through DEPTH stages on CE,
// any stage readable via tap address A, last stage on Q_LAST, saturating fill counter.
module srl_bus #(
    parameter int                     WIDTH         = 8,
    parameter int                     DEPTH         = 32,
    parameter logic [WIDTH*DEPTH-1:0] INIT          = '0,
    parameter bit                     OUT_REG       = 1'b0,
    parameter bit                     IS_C_INVERTED = 1'b0,
    localparam int                    AW            = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int                    FW            = $clog2(DEPTH + 1)
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    A,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_LAST,
    output logic [FW-1:0]    FILL,
    output logic             FULL
);

    // XOR folds the edge selection into one clock net so all storage uses posedge.
    logic clk_act;
    assign clk_act = C ^ IS_C_INVERTED;

    logic [DEPTH-1:0][WIDTH-1:0] s_q = INIT;
    logic [DEPTH-1:0][WIDTH-1:0] s_d;
    logic [FW-1:0]               fill_q = FW'(DEPTH);
    logic [FW-1:0]               fill_d;
    logic                        full;
    logic [WIDTH-1:0]            tap;

    assign full = (fill_q == FW'(DEPTH));

    always_comb begin
        s_d    = s_q;
        fill_d = fill_q;
        if (CE) begin
            s_d    = {s_q[DEPTH-2:0], D};
            fill_d = full ? fill_q : fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk_act or negedge CLR_N) begin
        if (!CLR_N) begin
            s_q    <= '0;
            fill_q <= '0;
        end else begin
            s_q    <= s_d;
            fill_q <= fill_d;
        end
    end

    // Addresses past the last stage (non-power-of-two DEPTH) read as zero, never alias.
    always_comb begin
        tap = '0;
        if (int'(A) < DEPTH) tap = s_q[A];
    end

    generate
        if (OUT_REG) begin : g_qreg
            logic [WIDTH-1:0] q_q = INIT[WIDTH-1:0];
            always_ff @(posedge clk_act or negedge CLR_N) begin
                if (!CLR_N) q_q <= '0;
                else        q_q <= tap;
            end
            assign Q = q_q;
        end else begin : g_qcomb
            assign Q = tap;
        end
    endgenerate

    assign Q_LAST = s_q[DEPTH-1];
    assign FILL   = fill_q;
    assign FULL   = full;

endmodule

// File: tb/tb_srl_bus.sv
// Directed bench for srl_bus: four instances (comb tap, registered tap, DEPTH=12, inverted clock)
// sharing one stimulus stream, with a scoreboard queue for per-edge tap expectations.
module tb_srl_bus;

    localparam logic [127:0] INIT16 = 128'h0F0E0D0C0B0A09080706050403020100;

    logic       C = 1'b0;
    logic       CLR_N = 1'b1;
    logic       CE = 1'b0;
    logic [7:0] D = '0;
    logic [3:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
    logic [7:0] q0, q1, q2, q3, ql0, ql1, ql2, ql3;
    logic [4:0] f0, f1, f3;
    logic [3:0] f2;
    logic       fu0, fu1, fu2, fu3;

    int checks = 0;
    int failures = 0;
    logic [7:0] sbq[$];
    logic [7:0] e0, e1;

    always #5 C = ~C;

    srl_bus #(.WIDTH(8), .DEPTH(16), .INIT(INIT16), .OUT_REG(1'b0), .IS_C_INVERTED(1'b0)) u0 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .D(D), .A(a0), .Q(q0), .Q_LAST(ql0), .FILL(f0), .FULL(fu0));
    srl_bus #(.WIDTH(8), .DEPTH(16), .INIT(INIT16), .OUT_REG(1'b1), .IS_C_INVERTED(1'b0)) u1 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .D(D), .A(a1), .Q(q1), .Q_LAST(ql1), .FILL(f1), .FULL(fu1));
    srl_bus #(.WIDTH(8), .DEPTH(12), .INIT('0), .OUT_REG(1'b0), .IS_C_INVERTED(1'b0)) u2 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .D(D), .A(a2), .Q(q2), .Q_LAST(ql2), .FILL(f2), .FULL(fu2));
    srl_bus #(.WIDTH(8), .DEPTH(16), .INIT(INIT16), .OUT_REG(1'b0), .IS_C_INVERTED(1'b1)) u3 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .D(D), .A(a3), .Q(q3), .Q_LAST(ql3), .FILL(f3), .FULL(fu3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic pulse_clear();
        CLR_N = 1'b0;
        #1;
        CLR_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up contents, no clear
        a0 = 4'd5; a1 = 4'd0;
        #1;
        chk("pwr_q", q0, 8'h05);
        chk("pwr_qlast", ql0, 8'h0F);
        chk("pwr_fill", f0, 16);
        chk("pwr_full", fu0, 1);
        chk("pwr_qreg", q1, 8'h00);
        chk("pwr_fill12", f2, 12);

        // Asynchronous clear between edges
        tick();
        CLR_N = 1'b0;
        #1;
        chk("clr_q", q0, 0);
        chk("clr_qlast", ql0, 0);
        chk("clr_fill", f0, 0);
        chk("clr_full", fu0, 0);
        chk("clr_qreg", q1, 0);
        CLR_N = 1'b1;

        // Fill 16 words; stage 0 tap follows D one edge later
        a0 = 4'd0;
        for (int n = 0; n < 16; n++) begin
            D = 8'hA0 + 8'(n); CE = 1'b1;
            sbq.push_back(8'hA0 + 8'(n));
            tick();
            e0 = sbq.pop_front();
            chk("fill_tap0", q0, e0);
            if (n == 14) chk("fill_notfull", fu0, 0);
        end
        CE = 1'b0;
        chk("fill_cnt", f0, 16);
        chk("fill_full", fu0, 1);
        chk("fill_qlast", ql0, 8'hA0);
        chk("fill_a0", q0, 8'hAF);
        tick();
        chk("fill_sat", f0, 16);

        // DEPTH=12 out-of-range addressing
        a2 = 4'd13; #1; chk("d12_a13", q2, 0);
        a2 = 4'd12; #1; chk("d12_a12", q2, 0);
        a2 = 4'd11; #1; chk("d12_a11", q2, 8'hA4);
        chk("d12_qlast", ql2, 8'hA4);
        chk("d12_full", fu2, 1);

        // Tap latency A=3, single 5A pulse
        tick();
        pulse_clear();
        a0 = 4'd3; a1 = 4'd3;
        for (int j = 1; j <= 10; j++) begin
            D = (j == 1) ? 8'h5A : 8'h00; CE = 1'b1;
            sbq.push_back((j == 4) ? 8'h5A : 8'h00);
            sbq.push_back((j == 5) ? 8'h5A : 8'h00);
            tick();
            e0 = sbq.pop_front();
            e1 = sbq.pop_front();
            chk($sformatf("lat_comb_e%0d", j), q0, e0);
            chk($sformatf("lat_reg_e%0d", j), q1, e1);
        end

        // CE stall
        pulse_clear();
        a0 = 4'd2;
        D = 8'h11; CE = 1'b1; tick();
        D = 8'h22; tick();
        D = 8'h33; tick();
        for (int s = 0; s < 5; s++) begin
            CE = 1'b0; D = 8'hE0 + 8'(s);
            tick();
            chk("stall_q", q0, 8'h11);
            chk("stall_fill", f0, 3);
        end
        D = 8'h44; CE = 1'b1; tick(); CE = 1'b0;
        chk("resume_fill", f0, 4);
        a0 = 4'd3; #1; chk("resume_a3", q0, 8'h11);
        a0 = 4'd2; #1; chk("resume_a2", q0, 8'h22);
        a0 = 4'd1; #1; chk("resume_a1", q0, 8'h33);
        a0 = 4'd0; #1; chk("resume_a0", q0, 8'h44);

        // Clear coincident with an active edge during a CE stream
        D = 8'h55; CE = 1'b1;
        tick(); tick(); tick();
        @(posedge C);
        CLR_N = 1'b0;
        #1;
        chk("mid_q", q0, 0);
        chk("mid_qlast", ql0, 0);
        chk("mid_fill", f0, 0);
        chk("mid_qreg", q1, 0);
        CLR_N = 1'b1;
        D = 8'h77; CE = 1'b1;
        tick();
        CE = 1'b0;
        chk("rel_s0", q0, 8'h77);
        chk("rel_fill", f0, 1);
        chk("rel_full", fu0, 0);
        a0 = 4'd1; #1; chk("rel_s1", q0, 0);

        // Inverted clock: only falling edges shift
        pulse_clear();
        a0 = 4'd0; a3 = 4'd0;
        D = 8'h3C; CE = 1'b1;
        @(negedge C); #1;
        chk("inv_fall_q", q3, 8'h3C);
        chk("inv_fall_fill", f3, 1);
        chk("inv_rise_dut_fill", f0, 0);
        D = 8'hC3;
        @(posedge C); #1;
        chk("inv_rise_q", q3, 8'h3C);
        chk("inv_rise_fill", f3, 1);
        chk("norm_rise_q", q0, 8'hC3);
        @(negedge C); #1;
        CE = 1'b0;
        chk("inv_fall2_q", q3, 8'hC3);
        chk("inv_fall2_fill", f3, 2);
        a3 = 4'd1; #1; chk("inv_fall2_s1", q3, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
